// File: rtl/usb_defs_pkg.sv
// Shared USB transaction definitions: token, DATA PID and handshake codes,
// sequencer states and the registered response bundle.
package usb_defs_pkg;

  typedef enum logic [1:0] {
    TOK_OUT   = 2'b00,
    TOK_BAD   = 2'b01,
    TOK_IN    = 2'b10,
    TOK_SETUP = 2'b11
  } tok_t;

  typedef enum logic [1:0] {
    PID_DATA0 = 2'b00,
    PID_DATA1 = 2'b10
  } pid_t;

  typedef enum logic [1:0] {
    HSK_ACK   = 2'b00,
    HSK_NYET  = 2'b01,
    HSK_NAK   = 2'b10,
    HSK_STALL = 2'b11
  } hsk_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RX_DATA,
    S_TX_DATA,
    S_WAIT_HSK
  } state_t;

  typedef struct packed {
    logic hsk_send;
    hsk_t hsk_type;
    logic tx_start;
    pid_t tx_pid;
    logic out_commit;
    logic out_discard;
    logic in_ack;
    logic in_retry;
    logic timeout;
  } resp_t;

  function automatic pid_t toggle_pid(input logic t);
    return t ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usb_trn_control_if.sv
// Bundle between the transaction sequencer and its neighbours
// (packet decoder, Tx encoder, endpoint cores).
interface usb_trn_control_if #(parameter int NUM_EP = 4);
  logic              trn_start_i;
  logic [1:0]        trn_type_i;
  logic [3:0]        trn_endpoint_i;
  logic              rx_trn_end_i;
  logic [1:0]        rx_trn_type_i;
  logic              crc_err_i;
  logic              trn_hsk_recv_i;
  logic [1:0]        trn_hsk_type_i;
  logic [NUM_EP-1:0] ep_ready_i;
  logic [NUM_EP-1:0] ep_halt_i;
  logic [NUM_EP-1:0] ep_toggle_clr_i;
  logic              tx_done_i;
  logic              hsk_send_o;
  logic [1:0]        hsk_type_o;
  logic              tx_start_o;
  logic [1:0]        tx_pid_o;
  logic [3:0]        ep_sel_o;
  logic              out_commit_o;
  logic              out_discard_o;
  logic              in_ack_o;
  logic              in_retry_o;
  logic              timeout_o;
  logic              busy_o;

  modport master (
    output trn_start_i, trn_type_i, trn_endpoint_i, rx_trn_end_i, rx_trn_type_i,
           crc_err_i, trn_hsk_recv_i, trn_hsk_type_i, ep_ready_i, ep_halt_i,
           ep_toggle_clr_i, tx_done_i,
    input  hsk_send_o, hsk_type_o, tx_start_o, tx_pid_o, ep_sel_o, out_commit_o,
           out_discard_o, in_ack_o, in_retry_o, timeout_o, busy_o
  );

  modport slave (
    input  trn_start_i, trn_type_i, trn_endpoint_i, rx_trn_end_i, rx_trn_type_i,
           crc_err_i, trn_hsk_recv_i, trn_hsk_type_i, ep_ready_i, ep_halt_i,
           ep_toggle_clr_i, tx_done_i,
    output hsk_send_o, hsk_type_o, tx_start_o, tx_pid_o, ep_sel_o, out_commit_o,
           out_discard_o, in_ack_o, in_retry_o, timeout_o, busy_o
  );
endinterface

// File: rtl/ep_toggle_bank.sv
// Per-endpoint DATA0/1 toggle registers for the IN and OUT directions.
// Clear wins over set-to-DATA1, which wins over flip.
module ep_toggle_bank #(
  parameter int NUM_EP = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_EP-1:0] flip_in,
  input  logic [NUM_EP-1:0] flip_out,
  input  logic [NUM_EP-1:0] set1,
  input  logic [NUM_EP-1:0] clr,
  output logic [NUM_EP-1:0] in_tog,
  output logic [NUM_EP-1:0] out_tog
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_tog  <= '0;
      out_tog <= '0;
    end else begin
      in_tog  <= ~clr & (set1 | (in_tog ^ flip_in));
      out_tog <= ~clr & (set1 | (out_tog ^ flip_out));
    end
  end

endmodule

// File: rtl/usb_trn_control.sv
// Device-side USB transaction sequencer: answers tokens, tracks DATA0/1
// toggles and tells the endpoint buffers to commit, discard, retire or retry.
module usb_trn_control
  import usb_defs_pkg::*;
#(
  parameter int NUM_EP  = 4,
  parameter int TIMEOUT = 100
) (
  input logic              clock,
  input logic              reset_n,
  usb_trn_control_if.slave bus
);

  localparam int EPW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_q, state_d;
  tok_t              type_q, type_d;
  logic [3:0]        ep_q, ep_d;
  logic [TW-1:0]     timer_q;
  resp_t             resp_q, resp_d;
  logic              restart, tok_ok, timer_hit;
  logic [EPW-1:0]    tok_idx, cur_idx;
  logic [NUM_EP-1:0] flip_in, flip_out, set1, in_tog, out_tog;

  assign tok_idx   = bus.trn_endpoint_i[EPW-1:0];
  assign cur_idx   = ep_q[EPW-1:0];
  assign tok_ok    = bus.trn_start_i && (int'(bus.trn_endpoint_i) < NUM_EP) &&
                     (bus.trn_type_i != TOK_BAD);
  assign timer_hit = (timer_q == TW'(TIMEOUT - 1));

  ep_toggle_bank #(.NUM_EP(NUM_EP)) u_toggles (
    .clock    (clock),
    .reset_n  (reset_n),
    .flip_in  (flip_in),
    .flip_out (flip_out),
    .set1     (set1),
    .clr      (bus.ep_toggle_clr_i),
    .in_tog   (in_tog),
    .out_tog  (out_tog)
  );

  always_comb begin
    state_d         = state_q;
    type_d          = type_q;
    ep_d            = ep_q;
    restart         = 1'b0;
    resp_d          = '0;
    resp_d.hsk_type = resp_q.hsk_type;
    resp_d.tx_pid   = resp_q.tx_pid;
    flip_in         = '0;
    flip_out        = '0;
    set1            = '0;

    if (tok_ok) begin
      // A new token aborts whatever is in flight, then is handled as from IDLE.
      resp_d.out_discard = (state_q == S_RX_DATA);
      resp_d.in_retry    = (state_q == S_TX_DATA) || (state_q == S_WAIT_HSK);
      type_d  = tok_t'(bus.trn_type_i);
      ep_d    = bus.trn_endpoint_i;
      restart = 1'b1;
      if (bus.trn_type_i == TOK_IN) begin
        state_d = S_IDLE;
        if (bus.ep_halt_i[tok_idx]) begin
          resp_d.hsk_send = 1'b1;
          resp_d.hsk_type = HSK_STALL;
        end else if (!bus.ep_ready_i[tok_idx]) begin
          resp_d.hsk_send = 1'b1;
          resp_d.hsk_type = HSK_NAK;
        end else begin
          resp_d.tx_start = 1'b1;
          resp_d.tx_pid   = toggle_pid(in_tog[tok_idx]);
          state_d         = S_TX_DATA;
        end
      end else begin
        state_d = S_RX_DATA;
      end
    end else begin
      case (state_q)
        S_RX_DATA: begin
          if (bus.rx_trn_end_i) begin
            state_d = S_IDLE;
            if (bus.crc_err_i) begin
              resp_d.out_discard = 1'b1;
            end else if (type_q == TOK_SETUP) begin
              if (bus.rx_trn_type_i != PID_DATA0) begin
                resp_d.out_discard = 1'b1;
              end else begin
                resp_d.hsk_send   = 1'b1;
                resp_d.hsk_type   = HSK_ACK;
                resp_d.out_commit = 1'b1;
                set1[cur_idx]     = 1'b1;
              end
            end else if (bus.ep_halt_i[cur_idx]) begin
              resp_d.hsk_send    = 1'b1;
              resp_d.hsk_type    = HSK_STALL;
              resp_d.out_discard = 1'b1;
            end else if (bus.rx_trn_type_i != toggle_pid(out_tog[cur_idx])) begin
              resp_d.hsk_send    = 1'b1;
              resp_d.hsk_type    = HSK_ACK;
              resp_d.out_discard = 1'b1;
            end else if (!bus.ep_ready_i[cur_idx]) begin
              resp_d.hsk_send    = 1'b1;
              resp_d.hsk_type    = HSK_NAK;
              resp_d.out_discard = 1'b1;
            end else begin
              resp_d.hsk_send   = 1'b1;
              resp_d.hsk_type   = HSK_ACK;
              resp_d.out_commit = 1'b1;
              flip_out[cur_idx] = 1'b1;
            end
          end else if (timer_hit) begin
            state_d            = S_IDLE;
            resp_d.timeout     = 1'b1;
            resp_d.out_discard = 1'b1;
          end
        end
        S_TX_DATA: begin
          if (bus.tx_done_i) begin
            state_d = S_WAIT_HSK;
          end else if (timer_hit) begin
            state_d         = S_IDLE;
            resp_d.timeout  = 1'b1;
            resp_d.in_retry = 1'b1;
          end
        end
        S_WAIT_HSK: begin
          if (bus.trn_hsk_recv_i) begin
            state_d = S_IDLE;
            if (bus.trn_hsk_type_i == HSK_ACK) begin
              resp_d.in_ack    = 1'b1;
              flip_in[cur_idx] = 1'b1;
            end else begin
              resp_d.in_retry = 1'b1;
            end
          end else if (timer_hit) begin
            state_d         = S_IDLE;
            resp_d.timeout  = 1'b1;
            resp_d.in_retry = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      type_q  <= TOK_OUT;
      ep_q    <= '0;
      timer_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      ep_q    <= ep_d;
      resp_q  <= resp_d;
      if (restart || (state_d != state_q)) begin
        timer_q <= '0;
      end else if (state_q != S_IDLE) begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign bus.hsk_send_o    = resp_q.hsk_send;
  assign bus.hsk_type_o    = resp_q.hsk_type;
  assign bus.tx_start_o    = resp_q.tx_start;
  assign bus.tx_pid_o      = resp_q.tx_pid;
  assign bus.ep_sel_o      = ep_q;
  assign bus.out_commit_o  = resp_q.out_commit;
  assign bus.out_discard_o = resp_q.out_discard;
  assign bus.in_ack_o      = resp_q.in_ack;
  assign bus.in_retry_o    = resp_q.in_retry;
  assign bus.timeout_o     = resp_q.timeout;
  assign bus.busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_trn_control.sv
// Directed scenario bench for the USB transaction sequencer.
module tb_usb_trn_control;
  import usb_defs_pkg::*;

  localparam int NUM_EP  = 4;
  localparam int TIMEOUT = 100;

  // Pulse/status flag vector: {hsk_send, tx_start, commit, discard, in_ack, in_retry, timeout, busy}
  localparam logic [7:0] P_HSK    = 8'h80;
  localparam logic [7:0] P_TX     = 8'h40;
  localparam logic [7:0] P_COMMIT = 8'h20;
  localparam logic [7:0] P_DISC   = 8'h10;
  localparam logic [7:0] P_ACK    = 8'h08;
  localparam logic [7:0] P_RETRY  = 8'h04;
  localparam logic [7:0] P_TMO    = 8'h02;
  localparam logic [7:0] P_BUSY   = 8'h01;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  usb_trn_control_if #(.NUM_EP(NUM_EP)) bus ();

  usb_trn_control #(.NUM_EP(NUM_EP), .TIMEOUT(TIMEOUT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] flags();
    return {bus.hsk_send_o, bus.tx_start_o, bus.out_commit_o, bus.out_discard_o,
            bus.in_ack_o, bus.in_retry_o, bus.timeout_o, bus.busy_o};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic token(input logic [1:0] t, input logic [3:0] ep);
    bus.trn_start_i = 1'b1; bus.trn_type_i = t; bus.trn_endpoint_i = ep;
    tick();
    bus.trn_start_i = 1'b0;
  endtask

  task automatic data(input logic [1:0] pid, input logic crc);
    bus.rx_trn_end_i = 1'b1; bus.rx_trn_type_i = pid; bus.crc_err_i = crc;
    tick();
    bus.rx_trn_end_i = 1'b0; bus.crc_err_i = 1'b0;
  endtask

  task automatic hsk(input logic [1:0] h);
    bus.trn_hsk_recv_i = 1'b1; bus.trn_hsk_type_i = h;
    tick();
    bus.trn_hsk_recv_i = 1'b0;
  endtask

  task automatic txdone();
    bus.tx_done_i = 1'b1;
    tick();
    bus.tx_done_i = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    if (flags() !== 8'h00) begin $display("FAIL reset_flags: got %b expected %b", flags(), 8'h00); n_fail++; end n_chk++;
    if ({bus.hsk_type_o, bus.tx_pid_o, bus.ep_sel_o} !== 8'h00) begin $display("FAIL reset_fields: got %h expected 00", {bus.hsk_type_o, bus.tx_pid_o, bus.ep_sel_o}); n_fail++; end n_chk++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_out_ack();
    token(TOK_OUT, 4'd1);
    if (flags() !== P_BUSY) begin $display("FAIL out_tok_flags: got %b expected %b", flags(), P_BUSY); n_fail++; end n_chk++;
    if (bus.ep_sel_o !== 4'd1) begin $display("FAIL out_tok_ep_sel: got %0d expected 1", bus.ep_sel_o); n_fail++; end n_chk++;
    data(PID_DATA0, 1'b0);
    if (flags() !== (P_HSK | P_COMMIT)) begin $display("FAIL out_ack_flags: got %b expected %b", flags(), P_HSK | P_COMMIT); n_fail++; end n_chk++;
    if (bus.hsk_type_o !== 2'b00) begin $display("FAIL out_ack_type: got %b expected 00", bus.hsk_type_o); n_fail++; end n_chk++;
  endtask

  task automatic test_out_dup();
    token(TOK_OUT, 4'd1);
    data(PID_DATA0, 1'b0);
    if (flags() !== (P_HSK | P_DISC)) begin $display("FAIL out_dup_flags: got %b expected %b", flags(), P_HSK | P_DISC); n_fail++; end n_chk++;
    if (bus.hsk_type_o !== 2'b00) begin $display("FAIL out_dup_type: got %b expected 00", bus.hsk_type_o); n_fail++; end n_chk++;
    token(TOK_OUT, 4'd1);
    data(PID_DATA1, 1'b0);
    if (flags() !== (P_HSK | P_COMMIT)) begin $display("FAIL out_data1_flags: got %b expected %b", flags(), P_HSK | P_COMMIT); n_fail++; end n_chk++;
  endtask

  task automatic test_in_ack();
    token(TOK_IN, 4'd2);
    if (flags() !== (P_TX | P_BUSY)) begin $display("FAIL in_start_flags: got %b expected %b", flags(), P_TX | P_BUSY); n_fail++; end n_chk++;
    if (bus.tx_pid_o !== 2'b00) begin $display("FAIL in_start_pid: got %b expected 00", bus.tx_pid_o); n_fail++; end n_chk++;
    txdone();
    if (flags() !== P_BUSY) begin $display("FAIL in_txdone_flags: got %b expected %b", flags(), P_BUSY); n_fail++; end n_chk++;
    hsk(HSK_ACK);
    if (flags() !== P_ACK) begin $display("FAIL in_ack_flags: got %b expected %b", flags(), P_ACK); n_fail++; end n_chk++;
    token(TOK_IN, 4'd2);
    if (bus.tx_pid_o !== 2'b10) begin $display("FAIL in_next_pid: got %b expected 10", bus.tx_pid_o); n_fail++; end n_chk++;
    txdone();
    hsk(HSK_NAK);
    if (flags() !== P_RETRY) begin $display("FAIL in_nak_flags: got %b expected %b", flags(), P_RETRY); n_fail++; end n_chk++;
    token(TOK_IN, 4'd2);
    if (bus.tx_pid_o !== 2'b10) begin $display("FAIL in_retry_pid: got %b expected 10", bus.tx_pid_o); n_fail++; end n_chk++;
  endtask

  task automatic test_in_timeout();
    int cnt = 0;
    txdone();
    while (!bus.timeout_o && cnt < 2 * TIMEOUT) begin
      tick();
      cnt++;
    end
    if (cnt !== TIMEOUT) begin $display("FAIL tmo_cycles: got %0d expected %0d", cnt, TIMEOUT); n_fail++; end n_chk++;
    if (flags() !== (P_RETRY | P_TMO)) begin $display("FAIL tmo_flags: got %b expected %b", flags(), P_RETRY | P_TMO); n_fail++; end n_chk++;
    token(TOK_IN, 4'd2);
    if (bus.tx_pid_o !== 2'b10) begin $display("FAIL tmo_pid_kept: got %b expected 10", bus.tx_pid_o); n_fail++; end n_chk++;
  endtask

  task automatic test_abort();
    token(TOK_OUT, 4'd1);
    if (flags() !== (P_RETRY | P_BUSY)) begin $display("FAIL abort_flags: got %b expected %b", flags(), P_RETRY | P_BUSY); n_fail++; end n_chk++;
    if (bus.ep_sel_o !== 4'd1) begin $display("FAIL abort_ep_sel: got %0d expected 1", bus.ep_sel_o); n_fail++; end n_chk++;
    data(PID_DATA0, 1'b0);
    if (flags() !== (P_HSK | P_COMMIT)) begin $display("FAIL abort_out_flags: got %b expected %b", flags(), P_HSK | P_COMMIT); n_fail++; end n_chk++;
  endtask

  task automatic test_setup_halt();
    bus.ep_halt_i = 4'b1001;
    token(TOK_SETUP, 4'd0);
    data(PID_DATA0, 1'b0);
    if (flags() !== (P_HSK | P_COMMIT)) begin $display("FAIL setup_flags: got %b expected %b", flags(), P_HSK | P_COMMIT); n_fail++; end n_chk++;
    if (bus.hsk_type_o !== 2'b00) begin $display("FAIL setup_type: got %b expected 00", bus.hsk_type_o); n_fail++; end n_chk++;
    bus.ep_halt_i = 4'b1000;
    token(TOK_IN, 4'd3);
    if (flags() !== P_HSK || bus.hsk_type_o !== 2'b11) begin $display("FAIL in_stall: got %b/%b expected %b/11", flags(), bus.hsk_type_o, P_HSK); n_fail++; end n_chk++;
    token(TOK_IN, 4'd0);
    if (bus.tx_pid_o !== 2'b10) begin $display("FAIL setup_in_pid: got %b expected 10", bus.tx_pid_o); n_fail++; end n_chk++;
    token(TOK_OUT, 4'd3);
    data(PID_DATA0, 1'b0);
    if (flags() !== (P_HSK | P_DISC) || bus.hsk_type_o !== 2'b11) begin $display("FAIL out_stall: got %b/%b expected %b/11", flags(), bus.hsk_type_o, P_HSK | P_DISC); n_fail++; end n_chk++;
    token(TOK_OUT, 4'd0);
    data(PID_DATA1, 1'b0);
    if (flags() !== (P_HSK | P_COMMIT)) begin $display("FAIL setup_out_tog: got %b expected %b", flags(), P_HSK | P_COMMIT); n_fail++; end n_chk++;
    bus.ep_halt_i = 4'b0000;
  endtask

  task automatic test_crc_nak();
    token(TOK_OUT, 4'd1);
    data(PID_DATA1, 1'b1);
    if (flags() !== P_DISC) begin $display("FAIL crc_flags: got %b expected %b", flags(), P_DISC); n_fail++; end n_chk++;
    bus.ep_ready_i = 4'b1101;
    token(TOK_OUT, 4'd1);
    data(PID_DATA1, 1'b0);
    if (flags() !== (P_HSK | P_DISC) || bus.hsk_type_o !== 2'b10) begin $display("FAIL nak: got %b/%b expected %b/10", flags(), bus.hsk_type_o, P_HSK | P_DISC); n_fail++; end n_chk++;
    bus.ep_ready_i = 4'b1111;
  endtask

  task automatic test_ignored();
    token(TOK_OUT, 4'd5);
    if (flags() !== 8'h00 || bus.ep_sel_o !== 4'd1) begin $display("FAIL bad_ep: got %b/%0d expected 00000000/1", flags(), bus.ep_sel_o); n_fail++; end n_chk++;
    txdone();
    hsk(HSK_ACK);
    data(PID_DATA0, 1'b0);
    if (flags() !== 8'h00) begin $display("FAIL stray_flags: got %b expected 00000000", flags()); n_fail++; end n_chk++;
  endtask

  task automatic test_toggle_clr();
    bus.ep_toggle_clr_i = 4'b0100;
    tick();
    bus.ep_toggle_clr_i = 4'b0000;
    token(TOK_IN, 4'd2);
    if (bus.tx_pid_o !== 2'b00) begin $display("FAIL clr_pid: got %b expected 00", bus.tx_pid_o); n_fail++; end n_chk++;
    txdone();
    hsk(HSK_ACK);
    token(TOK_IN, 4'd2);
    txdone();
    bus.ep_toggle_clr_i = 4'b0100;
    hsk(HSK_ACK);
    bus.ep_toggle_clr_i = 4'b0000;
    if (flags() !== P_ACK) begin $display("FAIL clr_ack_flags: got %b expected %b", flags(), P_ACK); n_fail++; end n_chk++;
    token(TOK_IN, 4'd2);
    if (bus.tx_pid_o !== 2'b00) begin $display("FAIL clr_beats_flip: got %b expected 00", bus.tx_pid_o); n_fail++; end n_chk++;
  endtask

  task automatic test_reset_mid();
    txdone();
    reset_n = 1'b0;
    #2;
    if (flags() !== 8'h00) begin $display("FAIL rst_mid_flags: got %b expected 00000000", flags()); n_fail++; end n_chk++;
    if ({bus.hsk_type_o, bus.tx_pid_o, bus.ep_sel_o} !== 8'h00) begin $display("FAIL rst_mid_fields: got %h expected 00", {bus.hsk_type_o, bus.tx_pid_o, bus.ep_sel_o}); n_fail++; end n_chk++;
    tick();
    reset_n = 1'b1;
    token(TOK_IN, 4'd0);
    if (bus.tx_pid_o !== 2'b00) begin $display("FAIL rst_in_pid: got %b expected 00", bus.tx_pid_o); n_fail++; end n_chk++;
    txdone();
    hsk(HSK_ACK);
    token(TOK_OUT, 4'd1);
    data(PID_DATA0, 1'b0);
    if (flags() !== (P_HSK | P_COMMIT)) begin $display("FAIL rst_out_tog: got %b expected %b", flags(), P_HSK | P_COMMIT); n_fail++; end n_chk++;
  endtask

  initial begin
    bus.trn_start_i = 1'b0; bus.trn_type_i = 2'b00; bus.trn_endpoint_i = 4'd0;
    bus.rx_trn_end_i = 1'b0; bus.rx_trn_type_i = 2'b00; bus.crc_err_i = 1'b0;
    bus.trn_hsk_recv_i = 1'b0; bus.trn_hsk_type_i = 2'b00; bus.tx_done_i = 1'b0;
    bus.ep_ready_i = 4'b1111; bus.ep_halt_i = 4'b0000; bus.ep_toggle_clr_i = 4'b0000;
    test_reset();
    test_out_ack();
    test_out_dup();
    test_in_ack();
    test_in_timeout();
    test_abort();
    test_setup_halt();
    test_crc_nak();
    test_ignored();
    test_toggle_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
